// File: rtl/store_monitor_if.sv
// Head-of-queue stream carrying captured stores from the monitor to its consumer.
// master = store_monitor (producer), slave = consumer.
interface store_monitor_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_adr;
    logic [31:0] out_data;
    logic [15:0] out_seq;

    modport master (
        output out_valid,
        output out_adr,
        output out_data,
        output out_seq,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_adr,
        input  out_data,
        input  out_seq,
        output out_ready
    );
endinterface

// File: rtl/store_monitor.sv
// Store-stream monitor: queues processor stores in a show-ahead FIFO and
// decides pass/fail from the store written to DONE_ADR.
module store_monitor #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] DONE_ADR  = 32'd100,
    parameter logic [31:0] DONE_DATA = 32'd25
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   MemWrite,
    input  logic [31:0]            DataAdr,
    input  logic [31:0]            WriteData,
    store_monitor_if.master        mon,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   pass,
    output logic                   fail,
    output logic [31:0]            cycles
);
    localparam int            AW         = $clog2(DEPTH);
    localparam int            CW         = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    state_t        state_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic [15:0]   seq_r;
    logic [31:0]   cycles_r;
    logic          valid_r;
    logic          overflow_r;
    logic          pass_r;
    logic          fail_r;

    logic [31:0]   adr_mem_r  [DEPTH];
    logic [31:0]   data_mem_r [DEPTH];
    logic [15:0]   seq_mem_r  [DEPTH];

    logic          push_req_s;
    logic          pop_s;
    logic          full_s;
    logic          push_s;
    logic          drop_s;
    logic          done_s;

    // Push/pop decode; a full FIFO still accepts a store when the head leaves on the same edge
    always_comb begin
        push_req_s  = 1'b0;
        count_nxt_s = count_r;
        if (MemWrite && (state_r == ST_RUN)) begin
            push_req_s = 1'b1;
        end else begin
            push_req_s = 1'b0;
        end
        pop_s  = valid_r & mon.out_ready;
        full_s = (count_r == FULL_COUNT);
        push_s = push_req_s & (~full_s | pop_s);
        drop_s = push_req_s & full_s & ~pop_s;
        done_s = push_req_s & (DataAdr == DONE_ADR);
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Outcome FSM with registered pass/fail and the RUN-cycle counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_RUN;
            pass_r   <= 1'b0;
            fail_r   <= 1'b0;
            cycles_r <= 32'd0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (cycles_r != 32'hFFFF_FFFF) begin
                        cycles_r <= cycles_r + 32'd1;
                    end else begin
                        cycles_r <= cycles_r;
                    end
                    if (done_s && (WriteData == DONE_DATA)) begin
                        state_r <= ST_PASS;
                        pass_r  <= 1'b1;
                        fail_r  <= 1'b0;
                    end else if (done_s) begin
                        state_r <= ST_FAIL;
                        pass_r  <= 1'b0;
                        fail_r  <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                        pass_r  <= 1'b0;
                        fail_r  <= 1'b0;
                    end
                end
                ST_PASS: begin
                    state_r <= ST_PASS;
                    pass_r  <= 1'b1;
                    fail_r  <= 1'b0;
                end
                ST_FAIL: begin
                    state_r <= ST_FAIL;
                    pass_r  <= 1'b0;
                    fail_r  <= 1'b1;
                end
                default: begin
                    // an illegal encoding is reported as a failed test
                    state_r <= ST_FAIL;
                    pass_r  <= 1'b0;
                    fail_r  <= 1'b1;
                end
            endcase
        end
    end

    // FIFO control: pointers, occupancy, sequence number and sticky overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            valid_r    <= 1'b0;
            seq_r      <= 16'd0;
            overflow_r <= 1'b0;
        end else begin
            count_r    <= count_nxt_s;
            valid_r    <= (count_nxt_s != {CW{1'b0}});
            overflow_r <= overflow_r | drop_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
                seq_r    <= seq_r + 16'd1;
            end else begin
                wr_ptr_r <= wr_ptr_r;
                seq_r    <= seq_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // FIFO storage; contents are hidden by valid_r after reset, so no reset needed
    always_ff @(posedge clk) begin
        if (push_s) begin
            adr_mem_r[wr_ptr_r]  <= DataAdr;
            data_mem_r[wr_ptr_r] <= WriteData;
            seq_mem_r[wr_ptr_r]  <= seq_r;
        end
    end

    // Show-ahead head and status outputs
    always_comb begin
        mon.out_valid = valid_r;
        mon.out_adr   = adr_mem_r[rd_ptr_r];
        mon.out_data  = data_mem_r[rd_ptr_r];
        mon.out_seq   = seq_mem_r[rd_ptr_r];
        count         = count_r;
        overflow      = overflow_r;
        pass          = pass_r;
        fail          = fail_r;
        cycles        = cycles_r;
    end
endmodule

// File: tb/tb_store_monitor.sv
// Self-checking bench for store_monitor: a reference queue of expected head
// entries is filled as stores are driven and compared as entries leave.
module tb_store_monitor;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          MemWrite  = 1'b0;
    logic [31:0]   DataAdr   = 32'd0;
    logic [31:0]   WriteData = 32'd0;
    logic [CW-1:0] count;
    logic          overflow;
    logic          pass;
    logic          fail;
    logic [31:0]   cycles;

    store_monitor_if mon_if ();

    store_monitor #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .mon       (mon_if.master),
        .count     (count),
        .overflow  (overflow),
        .pass      (pass),
        .fail      (fail),
        .cycles    (cycles)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [79:0] sb [$];
    logic [15:0] mseq     = 16'd0;
    logic        movf     = 1'b0;
    int          mstate   = 0;   // 0 RUN, 1 PASS, 2 FAIL
    logic [31:0] mcycles  = 32'd0;

    task automatic model_clear();
        sb.delete();
        mseq    = 16'd0;
        movf    = 1'b0;
        mstate  = 0;
        mcycles = 32'd0;
    endtask

    // Called at a falling edge: drive one cycle of stimulus, advance the model, return at next falling edge
    task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy);
        logic        push_req;
        logic        pop;
        logic        full;
        logic [79:0] dummy;
        MemWrite         = we;
        DataAdr          = a;
        WriteData        = d;
        mon_if.out_ready = rdy;
        push_req = we && (mstate == 0);
        pop      = (sb.size() != 0) && rdy;
        full     = (sb.size() == DEPTH);
        if (pop) dummy = sb.pop_front();
        if (push_req && (!full || pop)) begin
            sb.push_back({a, d, mseq});
            mseq = mseq + 16'd1;
        end else if (push_req) begin
            movf = 1'b1;
        end
        if (mstate == 0) begin
            mcycles = mcycles + 32'd1;
            if (push_req && (a == 32'd100)) mstate = (d == 32'd25) ? 1 : 2;
        end
        @(posedge clk);
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    // Called at a falling edge: short reset pulse, then one idle RUN cycle
    task automatic apply_reset();
        MemWrite         = 1'b0;
        mon_if.out_ready = 1'b0;
        reset            = 1'b0;
        #3;
        reset = 1'b1;
        model_clear();
        cycle(1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic test_reset();
        mon_if.out_ready = 1'b0;
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if ({mon_if.out_valid, count, overflow, pass, fail, cycles} !== {1'b0, {CW{1'b0}}, 1'b0, 1'b0, 1'b0, 32'd0})
            $display("FAIL reset_state: got valid=%b count=%0d ovf=%b pass=%b fail=%b cycles=%0d want all zero",
                     mon_if.out_valid, count, overflow, pass, fail, cycles);
        else n_pass++;
        @(negedge clk);
        #3 reset = 1'b1;
        model_clear();
        cycle(1'b0, 32'd0, 32'd0, 1'b0);
        n_checks++;
        if ({mon_if.out_valid, cycles} !== {1'b0, 32'd1})
            $display("FAIL reset_first_edge: got valid=%b cycles=%0d want valid=0 cycles=1", mon_if.out_valid, cycles);
        else n_pass++;
    endtask

    task automatic test_in_order();
        logic [31:0] adrs [3];
        logic [31:0] dats [3];
        adrs = '{32'h60, 32'h64, 32'h68};
        dats = '{32'd7, 32'd9, 32'd11};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({mon_if.out_valid, count} !== {sb.size() != 0, CW'(sb.size())})
                $display("FAIL in_order_count[%0d]: got valid=%b count=%0d want count=%0d", i, mon_if.out_valid, count, sb.size());
            else n_pass++;
            if (sb.size() != 0) begin
                n_checks++;
                if ({mon_if.out_adr, mon_if.out_data, mon_if.out_seq} !== sb[0] || mon_if.out_seq !== 16'(i - 1))
                    $display("FAIL in_order_head[%0d]: got %h/%0d seq %0d want %h seq %0d", i, mon_if.out_adr,
                             mon_if.out_data, mon_if.out_seq, sb[0], i - 1);
                else n_pass++;
            end
            if (i < 3) cycle(1'b1, adrs[i], dats[i], 1'b1);
            else cycle(1'b0, 32'd0, 32'd0, 1'b1);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b1, 32'h200 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0);
        n_checks++;
        if ({count, overflow, mon_if.out_valid} !== {CW'(DEPTH), 1'b1, 1'b1})
            $display("FAIL overflow_full: got count=%0d ovf=%b valid=%b want count=%0d ovf=1 valid=1",
                     count, overflow, mon_if.out_valid, DEPTH);
        else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if ({mon_if.out_adr, mon_if.out_data, mon_if.out_seq} !== sb[0] || mon_if.out_seq !== 16'(i)
                || mon_if.out_data !== 32'h1000 + 32'(i))
                $display("FAIL overflow_entry[%0d]: got %h/%h seq %0d want %h", i, mon_if.out_adr,
                         mon_if.out_data, mon_if.out_seq, sb[0]);
            else n_pass++;
            cycle(1'b0, 32'd0, 32'd0, 1'b1);
        end
        cycle(1'b1, 32'h300, 32'h55, 1'b0);
        n_checks++;
        if ({mon_if.out_valid, mon_if.out_seq, overflow, count} !== {1'b1, 16'(DEPTH), 1'b1, CW'(1)})
            $display("FAIL overflow_next_seq: got valid=%b seq=%0d ovf=%b count=%0d want seq=%0d ovf=1 count=1",
                     mon_if.out_valid, mon_if.out_seq, overflow, count, DEPTH);
        else n_pass++;
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h400 + 32'(4 * i), 32'h2000 + 32'(i), 1'b0);
        cycle(1'b1, 32'h500, 32'hABCD, 1'b1);
        n_checks++;
        if ({count, overflow} !== {CW'(DEPTH), 1'b0})
            $display("FAIL full_push_pop: got count=%0d ovf=%b want count=%0d ovf=0", count, overflow, DEPTH);
        else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if ({mon_if.out_adr, mon_if.out_data, mon_if.out_seq} !== sb[0])
                $display("FAIL full_drain[%0d]: got %h/%h seq %0d want %h", i, mon_if.out_adr,
                         mon_if.out_data, mon_if.out_seq, sb[0]);
            else n_pass++;
            if (i == DEPTH - 1) begin
                n_checks++;
                if ({mon_if.out_adr, mon_if.out_data, mon_if.out_seq} !== {32'h500, 32'hABCD, 16'(DEPTH)})
                    $display("FAIL full_tail: got %h/%h seq %0d want 500/abcd seq %0d", mon_if.out_adr,
                             mon_if.out_data, mon_if.out_seq, DEPTH);
                else n_pass++;
            end
            cycle(1'b0, 32'd0, 32'd0, 1'b1);
        end
        n_checks++;
        if ({mon_if.out_valid, count} !== {1'b0, {CW{1'b0}}})
            $display("FAIL full_empty: got valid=%b count=%0d want 0/0", mon_if.out_valid, count);
        else n_pass++;
    endtask

    task automatic test_pass();
        apply_reset();
        for (int i = 0; i < 15; i++) cycle(1'b0, 32'd0, 32'd0, 1'b0);
        cycle(1'b1, 32'd100, 32'd25, 1'b0);
        n_checks++;
        if ({pass, fail, cycles, count} !== {1'b1, 1'b0, 32'd17, CW'(1)} || mcycles !== 32'd17)
            $display("FAIL pass_decide: got pass=%b fail=%b cycles=%0d count=%0d want 1/0/17/1",
                     pass, fail, cycles, count);
        else n_pass++;
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h600 + 32'(i), 32'd7, 1'b0);
        n_checks++;
        if ({pass, cycles, count, mon_if.out_adr, mon_if.out_data, mon_if.out_seq} !==
            {1'b1, 32'd17, CW'(1), 32'd100, 32'd25, 16'd0})
            $display("FAIL pass_frozen: got pass=%b cycles=%0d count=%0d head=%0d/%0d seq %0d want 1/17/1 100/25 seq 0",
                     pass, cycles, count, mon_if.out_adr, mon_if.out_data, mon_if.out_seq);
        else n_pass++;
        cycle(1'b0, 32'd0, 32'd0, 1'b1);
        n_checks++;
        if ({mon_if.out_valid, count, pass} !== {1'b0, {CW{1'b0}}, 1'b1})
            $display("FAIL pass_drain: got valid=%b count=%0d pass=%b want 0/0/1", mon_if.out_valid, count, pass);
        else n_pass++;
    endtask

    task automatic test_fail();
        apply_reset();
        cycle(1'b1, 32'h70, 32'd1, 1'b0);
        cycle(1'b1, 32'd100, 32'd24, 1'b0);
        n_checks++;
        if ({fail, pass, count} !== {1'b1, 1'b0, CW'(2)} || mstate != 2)
            $display("FAIL fail_decide: got fail=%b pass=%b count=%0d want 1/0/2", fail, pass, count);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({mon_if.out_valid, fail, cycles, count} !== {1'b0, 1'b0, 32'd0, {CW{1'b0}}})
            $display("FAIL fail_async_reset: got valid=%b fail=%b cycles=%0d count=%0d want all zero",
                     mon_if.out_valid, fail, cycles, count);
        else n_pass++;
        #2 reset = 1'b1;
        model_clear();
        cycle(1'b0, 32'd0, 32'd0, 1'b0);
        n_checks++;
        if ({mon_if.out_valid, fail, cycles} !== {1'b0, 1'b0, 32'd1})
            $display("FAIL fail_after_reset: got valid=%b fail=%b cycles=%0d want 0/0/1", mon_if.out_valid, fail, cycles);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int          npop;
        logic        stalled;
        logic [79:0] prev_head;
        logic        rdy;
        npop    = 0;
        stalled = 1'b0;
        prev_head = 80'd0;
        apply_reset();
        for (int i = 0; i < 60; i++) begin
            if (i >= DEPTH + 3 && sb.size() == 0) break;
            rdy = i[0];
            if (sb.size() != 0) begin
                n_checks++;
                if ({mon_if.out_adr, mon_if.out_data, mon_if.out_seq} !== sb[0] || !mon_if.out_valid)
                    $display("FAIL wrap_head[%0d]: got %h/%h seq %0d want %h", i, mon_if.out_adr,
                             mon_if.out_data, mon_if.out_seq, sb[0]);
                else n_pass++;
                if (stalled) begin
                    n_checks++;
                    if ({mon_if.out_adr, mon_if.out_data, mon_if.out_seq} !== prev_head)
                        $display("FAIL wrap_stall[%0d]: got %h/%h seq %0d want %h", i, mon_if.out_adr,
                                 mon_if.out_data, mon_if.out_seq, prev_head);
                    else n_pass++;
                end
                if (rdy) npop++;
            end
            stalled   = (sb.size() != 0) && !rdy;
            prev_head = {mon_if.out_adr, mon_if.out_data, mon_if.out_seq};
            if (i < DEPTH + 3) cycle(1'b1, 32'h800 + 32'(4 * i), 32'hC000 + 32'(i), rdy);
            else cycle(1'b0, 32'd0, 32'd0, rdy);
        end
        n_checks++;
        if (npop != DEPTH + 3 || {count, overflow, mon_if.out_valid} !== {{CW{1'b0}}, 1'b0, 1'b0})
            $display("FAIL wrap_total: got pops=%0d count=%0d ovf=%b want pops=%0d count=0 ovf=0",
                     npop, count, overflow, DEPTH + 3);
        else n_pass++;
    endtask

    initial begin
        mon_if.out_ready = 1'b0;
        test_reset();
        test_in_order();
        test_overflow();
        test_full_push_pop();
        test_pass();
        test_fail();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
